out_byte_buffer: RTL and testbench

//  Parametrised console-output buffer between the CPU's byte-output port and its consumer
//  (UART transmitter or simulation monitor). Queues DATA_W-bit writes in a FIFO and

---
 rtl/out_byte_buffer_pkg.sv | 22 ++
 rtl/out_byte_buffer_sync_fifo.sv | 65 ++++++
 rtl/out_byte_buffer.sv | 171 +++++++++++++++++
 tb/tb_out_byte_buffer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/out_byte_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : out_byte_buffer_pkg
// Description : Shared definitions for the console-output byte buffer:
//               drain FSM state encodings and the level-width helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package out_byte_buffer_pkg;

   // Drain FSM encodings (kept as plain 2-bit constants for legacy tools)
   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // Width of a counter able to hold 0..depth inclusive
   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage : out_byte_buffer_pkg
`default_nettype wire

// File: rtl/out_byte_buffer_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : out_byte_buffer_sync_fifo
// Description : Storage array with wrap-around read/write pointers. The read
//               word is presented combinationally at the read pointer.
// Ports       : clk, reset        - clock, async active-high reset
//               wr_en, wr_data    - write strobe and word
//               rd_en, rd_data    - read (advance) strobe and head word
//               empty             - no words stored
// Revision    : 1.0 - initial release
// ============================================================================
module out_byte_buffer_sync_fifo #(
   parameter int DATA_W = 11,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;

   // Storage needs no reset; contents are only read when r_count says valid
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[r_wr_ptr] <= wr_data;
      end
   end

   // DEPTH is a power of two, so pointers wrap naturally on overflow
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (wr_en) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (rd_en) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({wr_en, rd_en})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign rd_data = mem[r_rd_ptr];
   assign empty   = (r_count == '0);

endmodule : out_byte_buffer_sync_fifo
`default_nettype wire

// File: rtl/out_byte_buffer.sv
`default_nettype none
// ============================================================================
// Module      : out_byte_buffer
// Description : Console-output buffer between the CPU byte port and its
//               consumer. Queues words, presents them over valid/ready from a
//               registered head, flushes on trap and reports drained, and
//               keeps sticky overflow / inactivity-timeout flags.
// Ports       : clk, reset            - clock, async active-high reset
//               in_data/valid/ready   - producer side
//               trap_in               - CPU trap level
//               out_data/valid/ready  - consumer side (registered head word)
//               level                 - words held, 0..DEPTH
//               overflow, timeout     - sticky status flags
//               drained               - trap seen and queue emptied
// Revision    : 1.0 - initial release
// ============================================================================
module out_byte_buffer
   import out_byte_buffer_pkg::*;
#(
   parameter int DATA_W       = 11,
   parameter int DEPTH        = 16,
   parameter bit DROP_ON_FULL = 1'b0,
   parameter int TIMEOUT_CYC  = 0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [DATA_W-1:0]             in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          trap_in,
   output logic [DATA_W-1:0]             out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [level_width(DEPTH)-1:0] level,
   output logic                          overflow,
   output logic                          timeout,
   output logic                          drained
);

   localparam int                LW       = level_width(DEPTH);
   localparam logic [LW-1:0]     FULL_LVL = LW'(DEPTH);
   localparam int                TW       = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [TW-1:0]     TMAX     = TW'(TIMEOUT_CYC);

   logic [1:0]        r_state;
   logic [LW-1:0]     r_level;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_valid;
   logic              r_overflow;
   logic              r_timeout;
   logic [TW-1:0]     r_tmo_cnt;

   logic              w_run;
   logic              w_room;
   logic              w_push;
   logic              w_drop;
   logic              w_pop;
   logic              w_load;
   logic              w_fifo_rd;
   logic              w_fifo_wr;
   logic              w_bypass;
   logic              w_fifo_empty;
   logic [DATA_W-1:0] w_fifo_data;
   logic [LW-1:0]     w_level_nxt;

   assign w_run  = (r_state == ST_RUN);
   assign w_room = (r_level != FULL_LVL);

   // Space is judged on the current level only: a same-cycle pop never
   // makes room for a push when full.
   assign in_ready = w_run && (w_room || DROP_ON_FULL);
   assign w_push   = in_valid && w_run && w_room;
   assign w_drop   = in_valid && w_run && !w_room && DROP_ON_FULL;
   assign w_pop    = r_out_valid && out_ready;

   // Head register refills whenever it is empty or being popped. An empty
   // FIFO lets a fresh push go straight into the head (1-cycle latency).
   assign w_load    = !r_out_valid || w_pop;
   assign w_fifo_rd = w_load && !w_fifo_empty;
   assign w_bypass  = w_load && w_fifo_empty && w_push;
   assign w_fifo_wr = w_push && !w_bypass;

   always_comb begin
      w_level_nxt = r_level;
      case ({w_push, w_pop})
         2'b10:   w_level_nxt = r_level + 1'b1;
         2'b01:   w_level_nxt = r_level - 1'b1;
         default: w_level_nxt = r_level;
      endcase
   end

   out_byte_buffer_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (w_fifo_wr),
      .wr_data (in_data),
      .rd_en   (w_fifo_rd),
      .rd_data (w_fifo_data),
      .empty   (w_fifo_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_RUN;
         r_level     <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_overflow  <= 1'b0;
         r_timeout   <= 1'b0;
         r_tmo_cnt   <= '0;
      end else begin
         r_level <= w_level_nxt;

         if (w_fifo_rd) begin
            r_out_data  <= w_fifo_data;
            r_out_valid <= 1'b1;
         end else if (w_bypass) begin
            r_out_data  <= in_data;
            r_out_valid <= 1'b1;
         end else if (w_pop) begin
            r_out_valid <= 1'b0;
         end

         if (w_drop) begin
            r_overflow <= 1'b1;
         end

         // Entering DONE as soon as the post-edge level is zero makes
         // drained appear the cycle right after the last pop.
         case (r_state)
            ST_RUN: begin
               if (trap_in) begin
                  r_state <= (w_level_nxt == '0) ? ST_DONE : ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (w_level_nxt == '0) begin
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: r_state <= ST_DONE;
            default: r_state <= ST_RUN;
         endcase

         if (TIMEOUT_CYC != 0) begin
            if (r_tmo_cnt == TMAX) begin
               r_timeout <= 1'b1;
            end
            if (w_run) begin
               if (w_push) begin
                  r_tmo_cnt <= '0;
               end else if (r_tmo_cnt != TMAX) begin
                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
               end
            end
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign level     = r_level;
   assign overflow  = r_overflow;
   assign timeout   = r_timeout;
   assign drained   = (r_state == ST_DONE);

endmodule : out_byte_buffer
`default_nettype wire

// File: tb/tb_out_byte_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_out_byte_buffer
// Description : Self-checking bench for out_byte_buffer (DATA_W=11, DEPTH=4,
//               DROP_ON_FULL=1, TIMEOUT_CYC=16). A behavioural model and a
//               scoreboard queue predict every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_out_byte_buffer;

   localparam int DW  = 11;
   localparam int DEP = 4;
   localparam int TMO = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          trap_in = 1'b0;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [2:0]    level;
   logic          overflow;
   logic          timeout;
   logic          drained;

   int n_assert = 0;
   int n_fail   = 0;

   // model state: 0 RUN, 1 DRAIN, 2 DONE
   int            m_level = 0;
   int            m_state = 0;
   int            m_cnt   = 0;
   bit            m_ovf   = 1'b0;
   bit            m_tmo   = 1'b0;
   logic [DW-1:0] sb [$];

   out_byte_buffer #(
      .DATA_W       (DW),
      .DEPTH        (DEP),
      .DROP_ON_FULL (1'b1),
      .TIMEOUT_CYC  (TMO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .trap_in   (trap_in),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .level     (level),
      .overflow  (overflow),
      .timeout   (timeout),
      .drained   (drained)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called mid-cycle (after negedge) with inputs already driven: check all
   // outputs against the model, then advance model and DUT one edge.
   task automatic tick();
      bit run, acc, pop;
      run = (m_state == 0);
      chk("in_ready",  in_ready,  run);
      chk("level",     level,     m_level);
      chk("out_valid", out_valid, m_level != 0);
      chk("overflow",  overflow,  m_ovf);
      chk("timeout",   timeout,   m_tmo);
      chk("drained",   drained,   m_state == 2);
      acc = in_valid && run && (m_level < DEP);
      pop = (m_level != 0) && out_ready;
      if (pop) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 1, 0);
         end else begin
            chk("out_data", out_data, sb.pop_front());
         end
      end
      if (acc) sb.push_back(in_data);
      if (m_cnt == TMO) m_tmo = 1'b1;
      if (run) begin
         if (acc) m_cnt = 0;
         else if (m_cnt != TMO) m_cnt++;
      end
      if (in_valid && run && m_level == DEP) m_ovf = 1'b1;
      m_level = m_level + int'(acc) - int'(pop);
      if (m_state == 0 && trap_in) m_state = (m_level == 0) ? 2 : 1;
      else if (m_state == 1 && m_level == 0) m_state = 2;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b0;
      trap_in  = 1'b0;
      #1;
      chk("rst_async_level", level, 0);
      chk("rst_async_valid", out_valid, 0);
      repeat (5) @(negedge clk);
      m_level = 0; m_state = 0; m_cnt = 0; m_ovf = 1'b0; m_tmo = 1'b0;
      sb.delete();
      chk("rst_out_data", out_data, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_timeout",  timeout,  0);
      chk("rst_drained",  drained,  0);
      reset = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 1);
   endtask

   task automatic push(input logic [DW-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      // reset state
      do_reset();
      tick();

      // single word, consumer ready: 1-cycle latency then popped
      out_ready = 1'b1;
      push(11'h041);
      chk("first_word_valid", out_valid, 1);
      chk("first_word_data", out_data, 11'h041);
      tick();
      tick();

      // fill to DEPTH, then drop a fifth word
      out_ready = 1'b0;
      push(11'h001);
      push(11'h002);
      push(11'h003);
      push(11'h004);
      chk("full_level", level, 4);
      push(11'h005);
      chk("drop_overflow", overflow, 1);
      out_ready = 1'b1;
      repeat (6) tick();

      // simultaneous push and pop at level 2
      out_ready = 1'b0;
      push(11'h010);
      push(11'h011);
      out_ready = 1'b1;
      push(11'h017);
      chk("pushpop_level", level, 2);
      repeat (4) tick();

      // trap with a same-cycle push, then ignored pushes, then drain
      do_reset();
      out_ready = 1'b0;
      push(11'h021);
      push(11'h022);
      push(11'h023);
      trap_in = 1'b1;
      push(11'h024);
      trap_in = 1'b0;
      chk("trap_push_level", level, 4);
      in_valid = 1'b1;
      in_data  = 11'h025;
      repeat (3) tick();
      chk("drain_no_overflow", overflow, 0);
      out_ready = 1'b1;
      repeat (4) tick();
      chk("drained_after_last_pop", drained, 1);
      repeat (3) tick();
      in_valid = 1'b0;
      tick();

      // inactivity timeout, then reset in the middle of a drain
      do_reset();
      out_ready = 1'b0;
      repeat (20) tick();
      chk("timeout_set", timeout, 1);
      push(11'h031);
      push(11'h032);
      trap_in = 1'b1;
      tick();
      trap_in = 1'b0;
      tick();
      do_reset();
      chk("mid_drain_reset_level", level, 0);
      chk("mid_drain_reset_ready", in_ready, 1);
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_out_byte_buffer
`default_nettype wire
